wb_regfile: RTL and testbench
=============================

# wb_regfile

Write-back stage and architectural register file for the pipelined MIPS core. It sits directly downstream of the MEM/WB pipeline register. It consumes that register's latched control bits, memory data, ALU result and destination register, and selects the write-back value. It commits that value to a 32×32 register file and serves the two combinational read ports used by the ID stage.

## Interface
Parameters:
- `DATA_W`, 32, register and data width
- `REG_N`, 32, number of architectural registers; `Rd`/`Rs`/`Rt` width is log2(`REG_N`)

Ports:
- `clk`  in  1  system clock, all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `WB_WB`  in  2  write-back control from MEM/WB: bit1 = RegWrite, bit0 = MemtoReg
- `WB_memory_Output`  in  32  load data from MEM/WB
- `WB_ALU_Output`  in  32  ALU result from MEM/WB
- `WB_Rd`  in  5  destination register from MEM/WB
- `Rs`  in  5  read port 1 address (ID stage)
- `Rt`  in  5  read port 2 address (ID stage)
- `Read_Data1`  out  32  read port 1 data
- `Read_Data2`  out  32  read port 2 data
- `WB_Write_Data`  out  32  selected write-back value, also fed to the forwarding unit
- `WB_Write_En`  out  1  effective write strobe: RegWrite && `WB_Rd` != 0
- `wb_count`  out  32  number of committed register writes since reset

## Operation
- Write-back select: `WB_Write_Data` = MemtoReg ? `WB_memory_Output` : `WB_ALU_Output`. Combinational.
- Commit: on each rising `clk` with `WB_Write_En` = 1, `regs[WB_Rd]` <= `WB_Write_Data`.
- Register 0 is hardwired to zero.
  - Writes to `WB_Rd` = 0 are discarded and do not assert `WB_Write_En`.
  - Reads of address 0 always return 0.
- Reads are combinational: `Read_Data1` = `regs[Rs]` and `Read_Data2` = `regs[Rt]`, subject to the bypass in Configuration.
- `wb_count` increments by 1 on each committed write and wraps from 0xFFFFFFFF to 0. Discarded writes (RegWrite = 0, or `WB_Rd` = 0) do not count.
- `WB_WB` = 2'b00/2'b01: no state change. `WB_Write_Data` is still driven; it is don't-care for the pipeline.

## Timing
- Reset: asserting `rst` immediately and asynchronously clears all 32 registers and `wb_count` to 0.
  - While `rst` = 1, `Read_Data1` = `Read_Data2` = 0 and no writes commit.
  - Reset asserted mid-operation discards any write on that edge.
- Reset-independent outputs: `WB_Write_Data` and `WB_Write_En` are combinational in inputs only. Their values under reset follow the inputs.
- Write latency: a value presented in cycle N is visible in `regs` after edge N→N+1.
- Read latency: 0 cycles, combinational from `Rs`/`Rt` and register contents.
- Same-cycle read/write to the same non-zero register: behaviour is governed by `WB_BYPASS_EN` (below).
- Both read ports may address the same register or `WB_Rd` simultaneously; each resolves independently.
- First edge after `rst` deasserts is a normal write edge.

## Configuration
- `WB_REGFILE_BYPASS_EN` defined:
  - If `WB_Write_En` = 1 and `Rs` == `WB_Rd`, `Read_Data1` = `WB_Write_Data` in the same cycle.
  - The same rule applies to `Rt`/`Read_Data2`.
  - This emulates write-first-half/read-second-half and removes the 3-instruction RAW hazard.
  - The bypass never applies to address 0.
- Not defined: reads return the stored `regs` value only. The new value appears the cycle after commit, and the hazard unit must stall one extra cycle.

## Test plan
- Reset: hold `rst` = 1 for 5 cycles with `WB_WB` = 2'b10, `WB_Rd` = 5 → `regs[5]` stays 0; `Read_Data1` (`Rs` = 5) = 0; `wb_count` = 0.
- ALU write-back: `WB_WB` = 2'b10, `WB_ALU_Output` = 0x0000_00AA, `WB_memory_Output` = 0x1234_5678, `WB_Rd` = 3 for one cycle, then `WB_WB` = 0 → `Rs` = 3 reads 0xAA; `wb_count` = 1.
- Load write-back: `WB_WB` = 2'b11, `WB_memory_Output` = 0xDEAD_BEEF, `WB_Rd` = 31 → `Rt` = 31 reads 0xDEADBEEF after the edge; `WB_Write_Data` = 0xDEADBEEF during the cycle.
- $zero: `WB_WB` = 2'b11, `WB_Rd` = 0, data 0xFFFF_FFFF → `WB_Write_En` = 0; `Rs` = 0 reads 0; `wb_count` unchanged.
- Same-cycle RAW: `WB_WB` = 2'b10, `WB_Rd` = 7, `WB_ALU_Output` = 0x55, `Rs` = `Rt` = 7, with old `regs[7]` = 0x11.
  - With `WB_REGFILE_BYPASS_EN`: both ports read 0x55 in that cycle.
  - Without: both read 0x11, then 0x55 after the edge.
- Async reset mid-stream: write 0x99 to reg 4, then assert `rst` between edges → `Read_Data1` (`Rs` = 4) drops to 0 before the next edge; `wb_count` = 0.

Source files
------------

// File: rtl/wb_regfile_if.sv
// Bus bundle between the MEM/WB pipeline register, the ID read ports and the
// write-back/register-file block.
interface wb_regfile_if #(
   parameter int DATA_W = 32,
   parameter int REG_N  = 32
);
   localparam int AW = $clog2(REG_N);

   logic [1:0]        WB_WB;
   logic [DATA_W-1:0] WB_memory_Output;
   logic [DATA_W-1:0] WB_ALU_Output;
   logic [AW-1:0]     WB_Rd;
   logic [AW-1:0]     Rs;
   logic [AW-1:0]     Rt;
   logic [DATA_W-1:0] Read_Data1;
   logic [DATA_W-1:0] Read_Data2;
   logic [DATA_W-1:0] WB_Write_Data;
   logic              WB_Write_En;
   logic [31:0]       wb_count;

   modport slave (
      input  WB_WB, WB_memory_Output, WB_ALU_Output, WB_Rd, Rs, Rt,
      output Read_Data1, Read_Data2, WB_Write_Data, WB_Write_En, wb_count
   );

   modport master (
      output WB_WB, WB_memory_Output, WB_ALU_Output, WB_Rd, Rs, Rt,
      input  Read_Data1, Read_Data2, WB_Write_Data, WB_Write_En, wb_count
   );
endinterface

// File: rtl/wb_regfile.sv
// Write-back select plus 32x32 register file with two combinational read ports.
// Optional same-cycle write-to-read bypass: define WB_REGFILE_BYPASS_EN.
module wb_regfile #(
   parameter int DATA_W = 32,
   parameter int REG_N  = 32
) (
   input  logic        clk,
   input  logic        rst,
   wb_regfile_if.slave bus
);
   localparam int AW = $clog2(REG_N);

   logic [DATA_W-1:0] regs_q [REG_N];
   logic [DATA_W-1:0] regs_d [REG_N];
   logic [31:0]       wb_count_q;
   logic [31:0]       wb_count_d;
   logic [DATA_W-1:0] wr_data_s;
   logic              wr_en_s;
   logic [DATA_W-1:0] rd1_s;
   logic [DATA_W-1:0] rd2_s;

   // Write-back value select and effective write strobe ($zero writes dropped)
   always_comb begin
      wr_data_s = bus.WB_ALU_Output;
      if (bus.WB_WB[0]) begin
         wr_data_s = bus.WB_memory_Output;
      end else begin
         wr_data_s = bus.WB_ALU_Output;
      end
      wr_en_s = bus.WB_WB[1] && (bus.WB_Rd != {AW{1'b0}});
   end

   // Next-state for register array and commit counter
   always_comb begin
      regs_d     = regs_q;
      wb_count_d = wb_count_q;
      if (wr_en_s) begin
         regs_d[bus.WB_Rd] = wr_data_s;
         wb_count_d        = wb_count_q + 32'd1;
      end else begin
         wb_count_d = wb_count_q;
      end
      regs_d[0] = {DATA_W{1'b0}};
   end

   // State registers, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < REG_N; i++) begin
            regs_q[i] <= {DATA_W{1'b0}};
         end
         wb_count_q <= 32'd0;
      end else begin
         regs_q     <= regs_d;
         wb_count_q <= wb_count_d;
      end
   end

   // Read port 1; reset forces zero even when the bypass would forward
   always_comb begin
      rd1_s = {DATA_W{1'b0}};
      if (rst || (bus.Rs == {AW{1'b0}})) begin
         rd1_s = {DATA_W{1'b0}};
`ifdef WB_REGFILE_BYPASS_EN
      end else if (wr_en_s && (bus.Rs == bus.WB_Rd)) begin
         rd1_s = wr_data_s;
`endif
      end else begin
         rd1_s = regs_q[bus.Rs];
      end
   end

   // Read port 2, resolved independently of port 1
   always_comb begin
      rd2_s = {DATA_W{1'b0}};
      if (rst || (bus.Rt == {AW{1'b0}})) begin
         rd2_s = {DATA_W{1'b0}};
`ifdef WB_REGFILE_BYPASS_EN
      end else if (wr_en_s && (bus.Rt == bus.WB_Rd)) begin
         rd2_s = wr_data_s;
`endif
      end else begin
         rd2_s = regs_q[bus.Rt];
      end
   end

   assign bus.Read_Data1    = rd1_s;
   assign bus.Read_Data2    = rd2_s;
   assign bus.WB_Write_Data = wr_data_s;
   assign bus.WB_Write_En   = wr_en_s;
   assign bus.wb_count      = wb_count_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset, ALU/load write-back, $zero, RAW, async reset.
module tb_wb_regfile;
   logic clk;
   logic rst;
   int   checks_cnt;
   int   errors_cnt;

   wb_regfile_if #(.DATA_W(32), .REG_N(32)) bus ();

   wb_regfile #(.DATA_W(32), .REG_N(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_cnt++;
      if (obs !== exp) begin
         errors_cnt++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] wb, input logic [31:0] mem, input logic [31:0] alu,
                        input logic [4:0] rd);
      bus.WB_WB            = wb;
      bus.WB_memory_Output = mem;
      bus.WB_ALU_Output    = alu;
      bus.WB_Rd            = rd;
   endtask

   initial begin
      checks_cnt = 0;
      errors_cnt = 0;
      rst    = 1'b1;
      bus.Rs = 5'd5;
      bus.Rt = 5'd5;
      drive(2'b10, 32'h0000_0000, 32'h0000_0077, 5'd5);

      // Reset held for 5 cycles with a pending write to reg 5
      repeat (5) tick();
      check_eq("rst_rd1", bus.Read_Data1, 32'h0000_0000);
      check_eq("rst_rd2", bus.Read_Data2, 32'h0000_0000);
      check_eq("rst_count", bus.wb_count, 32'd0);
      check_eq("rst_wen_follows_inputs", {31'd0, bus.WB_Write_En}, 32'd1);
      check_eq("rst_wdata_follows_inputs", bus.WB_Write_Data, 32'h0000_0077);
      rst = 1'b0;
      drive(2'b00, 32'h0, 32'h0, 5'd5);
      tick();
      check_eq("post_rst_reg5", bus.Read_Data1, 32'h0000_0000);

      // ALU write-back to reg 3
      bus.Rs = 5'd0;
      drive(2'b10, 32'h1234_5678, 32'h0000_00AA, 5'd3);
      #1;
      check_eq("alu_wdata", bus.WB_Write_Data, 32'h0000_00AA);
      check_eq("alu_wen", {31'd0, bus.WB_Write_En}, 32'd1);
      tick();
      drive(2'b00, 32'h1234_5678, 32'h0000_00AA, 5'd3);
      bus.Rs = 5'd3;
      #1;
      check_eq("alu_reg3", bus.Read_Data1, 32'h0000_00AA);
      check_eq("alu_count", bus.wb_count, 32'd1);

      // Load write-back to reg 31
      bus.Rt = 5'd30;
      drive(2'b11, 32'hDEAD_BEEF, 32'h0000_0001, 5'd31);
      #1;
      check_eq("load_wdata", bus.WB_Write_Data, 32'hDEAD_BEEF);
      tick();
      drive(2'b00, 32'h0, 32'h0, 5'd0);
      bus.Rt = 5'd31;
      #1;
      check_eq("load_reg31", bus.Read_Data2, 32'hDEAD_BEEF);
      check_eq("load_count", bus.wb_count, 32'd2);

      // Write to $zero is discarded
      bus.Rs = 5'd0;
      drive(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
      #1;
      check_eq("zero_wen", {31'd0, bus.WB_Write_En}, 32'd0);
      check_eq("zero_read_same_cycle", bus.Read_Data1, 32'h0000_0000);
      tick();
      check_eq("zero_read_after", bus.Read_Data1, 32'h0000_0000);
      check_eq("zero_count", bus.wb_count, 32'd2);

      // RegWrite=0 with MemtoReg=1: no state change
      bus.Rs = 5'd3;
      drive(2'b01, 32'h0000_CAFE, 32'h0000_0000, 5'd3);
      #1;
      check_eq("nowr_wdata", bus.WB_Write_Data, 32'h0000_CAFE);
      check_eq("nowr_wen", {31'd0, bus.WB_Write_En}, 32'd0);
      tick();
      check_eq("nowr_reg3", bus.Read_Data1, 32'h0000_00AA);
      check_eq("nowr_count", bus.wb_count, 32'd2);

      // Same-cycle RAW on reg 7 (old value 0x11)
      bus.Rs = 5'd0;
      bus.Rt = 5'd0;
      drive(2'b10, 32'h0, 32'h0000_0011, 5'd7);
      tick();
      drive(2'b10, 32'h0, 32'h0000_0055, 5'd7);
      bus.Rs = 5'd7;
      bus.Rt = 5'd7;
      #1;
`ifdef WB_REGFILE_BYPASS_EN
      check_eq("raw_rd1_same", bus.Read_Data1, 32'h0000_0055);
      check_eq("raw_rd2_same", bus.Read_Data2, 32'h0000_0055);
`else
      check_eq("raw_rd1_same", bus.Read_Data1, 32'h0000_0011);
      check_eq("raw_rd2_same", bus.Read_Data2, 32'h0000_0011);
`endif
      tick();
      drive(2'b00, 32'h0, 32'h0, 5'd0);
      #1;
      check_eq("raw_rd1_after", bus.Read_Data1, 32'h0000_0055);
      check_eq("raw_rd2_after", bus.Read_Data2, 32'h0000_0055);
      check_eq("raw_count", bus.wb_count, 32'd4);

      // Async reset mid-stream after writing 0x99 to reg 4
      drive(2'b10, 32'h0, 32'h0000_0099, 5'd4);
      tick();
      drive(2'b10, 32'h0, 32'h0000_0066, 5'd4);
      bus.Rs = 5'd4;
      bus.Rt = 5'd31;
      #1;
      check_eq("pre_arst_count", bus.wb_count, 32'd5);
`ifndef WB_REGFILE_BYPASS_EN
      check_eq("pre_arst_reg4", bus.Read_Data1, 32'h0000_0099);
`endif
      #1;
      rst = 1'b1;
      #1;
      check_eq("arst_reg4", bus.Read_Data1, 32'h0000_0000);
      check_eq("arst_reg31", bus.Read_Data2, 32'h0000_0000);
      check_eq("arst_count", bus.wb_count, 32'd0);
      tick();
      check_eq("arst_edge_discard", bus.Read_Data1, 32'h0000_0000);
      check_eq("arst_edge_count", bus.wb_count, 32'd0);

      // First edge after deassert is a normal write edge
      #2;
      rst = 1'b0;
      drive(2'b10, 32'h0, 32'h0000_0042, 5'd4);
      tick();
      drive(2'b00, 32'h0, 32'h0, 5'd0);
      #1;
      check_eq("first_edge_reg4", bus.Read_Data1, 32'h0000_0042);
      check_eq("first_edge_reg31", bus.Read_Data2, 32'h0000_0000);
      check_eq("first_edge_count", bus.wb_count, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end
endmodule
